// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register with a two-entry skid buffer.
// Latency: 1 cycle from accept to mem_valid (EMPTY, or BUSY with a drain).
// Backpressure: ex_ready = ~skid valid (registered, no mem_ready path); FULL holds both entries.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               synchronous flush, clears both entries at the next edge
//   ex_valid/ex_ready   handshake from EX; ex_wd, ex_wreg, ex_wdata carry the result
//   mem_valid/mem_ready handshake to MEM; mem_wd, mem_wreg, mem_wdata present the main entry
//   fwd_wreg/fwd_wd/fwd_wdata  bypass to ID from the youngest valid entry
//
// Build option: define EX_MEM_FWD_EN to compile the forwarding path;
// without it the fwd_* ports remain and are tied to zero.

module ex_mem #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ready,
  output logic              mem_valid,
  output logic [REG_AW-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              fwd_wreg,
  output logic [REG_AW-1:0] fwd_wd,
  output logic [DATA_W-1:0] fwd_wdata
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Main entry drives MEM; skid catches the one result that arrives while
  // main is stalled, which is what lets ex_ready ignore mem_ready.
  logic              main_valid, skid_valid;
  logic [REG_AW-1:0] main_wd,    skid_wd;
  logic              main_wreg,  skid_wreg;
  logic [DATA_W-1:0] main_wdata, skid_wdata;

  logic main_valid_nxt, skid_valid_nxt;
  logic main_load_ex;    // main <- EX input
  logic main_load_skid;  // main <- skid entry
  logic skid_load_ex;    // skid <- EX input

  logic accept, drain;

  assign ex_ready = ~skid_valid;
  assign accept   = ex_valid & ex_ready;
  assign drain    = mem_valid & mem_ready;

  assign mem_valid = main_valid;
  assign mem_wd    = main_wd;
  assign mem_wdata = main_wdata;
  assign mem_wreg  = main_valid & main_wreg;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and entry-load decode
  always_comb begin
    state_nxt      = state;
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_load_ex   = 1'b0;
    main_load_skid = 1'b0;
    skid_load_ex   = 1'b0;

    case (state)
      EMPTY: begin
        if (accept) begin
          main_load_ex   = 1'b1;
          main_valid_nxt = 1'b1;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          main_load_ex = 1'b1;
        end else if (accept) begin
          skid_load_ex   = 1'b1;
          skid_valid_nxt = 1'b1;
          state_nxt      = FULL;
        end else if (drain) begin
          main_valid_nxt = 1'b0;
          state_nxt      = EMPTY;
        end
      end
      FULL: begin
        // ex_ready is low here, so only a drain can move things.
        if (drain) begin
          main_load_skid = 1'b1;
          skid_valid_nxt = 1'b0;
          state_nxt      = BUSY;
        end
      end
      default: begin
        main_valid_nxt = 1'b0;
        skid_valid_nxt = 1'b0;
        state_nxt      = EMPTY;
      end
    endcase

    // Flush wins over everything, including a same-cycle accept or drain.
    // Payload fields are left as they are; only the valid bits drop.
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
      main_load_ex   = 1'b0;
      main_load_skid = 1'b0;
      skid_load_ex   = 1'b0;
      state_nxt      = EMPTY;
    end
  end

  // Main entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_wd    <= '0;
      main_wreg  <= 1'b0;
      main_wdata <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      if (main_load_ex) begin
        main_wd    <= ex_wd;
        main_wreg  <= ex_wreg;
        main_wdata <= ex_wdata;
      end else if (main_load_skid) begin
        main_wd    <= skid_wd;
        main_wreg  <= skid_wreg;
        main_wdata <= skid_wdata;
      end
    end
  end

  // Skid entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid <= 1'b0;
      skid_wd    <= '0;
      skid_wreg  <= 1'b0;
      skid_wdata <= '0;
    end else begin
      skid_valid <= skid_valid_nxt;
      if (skid_load_ex) begin
        skid_wd    <= ex_wd;
        skid_wreg  <= ex_wreg;
        skid_wdata <= ex_wdata;
      end
    end
  end

`ifdef EX_MEM_FWD_EN
  // Youngest valid entry wins: skid holds the newer result when present.
  always_comb begin
    fwd_wreg  = 1'b0;
    fwd_wd    = '0;
    fwd_wdata = '0;
    if (skid_valid) begin
      fwd_wreg  = skid_wreg;
      fwd_wd    = skid_wd;
      fwd_wdata = skid_wdata;
    end else if (main_valid) begin
      fwd_wreg  = main_wreg;
      fwd_wd    = main_wd;
      fwd_wdata = main_wdata;
    end
  end
`else
  assign fwd_wreg  = 1'b0;
  assign fwd_wd    = '0;
  assign fwd_wdata = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset values, single transfer, backpressure,
// streaming, flush, forwarding and asynchronous reset mid-operation.
module tb_ex_mem;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_wd;
  logic              ex_wreg;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_ready;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              fwd_wreg;
  logic [REG_AW-1:0] fwd_wd;
  logic [DATA_W-1:0] fwd_wdata;

  int errors = 0;
  int checks = 0;

  ex_mem #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_ready  (ex_ready),
    .mem_valid (mem_valid),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .fwd_wreg  (fwd_wreg),
    .fwd_wd    (fwd_wd),
    .fwd_wdata (fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_AW-1:0] wd, input logic wreg,
                       input logic [DATA_W-1:0] wdata);
    ex_valid = v;
    ex_wd    = wd;
    ex_wreg  = wreg;
    ex_wdata = wdata;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    #2;
    // Reset values
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_wreg",  mem_wreg,  0);
    check("rst_mem_wd",    mem_wd,    0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ex_ready",  ex_ready,  1);
    check("rst_fwd_wreg",  fwd_wreg,  0);
    check("rst_fwd_wdata", fwd_wdata, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_mem_valid", mem_valid, 0);

    // Single transfer
    mem_ready = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h0000_00FF);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    check("single_mem_valid", mem_valid, 1);
    check("single_mem_wd",    mem_wd,    3);
    check("single_mem_wdata", mem_wdata, 32'hFF);
    check("single_mem_wreg",  mem_wreg,  1);
    check("single_ex_ready",  ex_ready,  1);
    tick();
    check("single_drained", mem_valid, 0);

    // Backpressure: A, B fill both entries, C is held off
    mem_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'h11);
    tick();
    check("bp_a_present", mem_wdata, 32'h11);
    check("bp_busy_ready", ex_ready, 1);
    drive(1'b1, 5'd2, 1'b1, 32'h22);
    tick();
    check("bp_full_ready", ex_ready, 0);
    check("bp_full_head",  mem_wdata, 32'h11);
    drive(1'b1, 5'd4, 1'b1, 32'h33);
    tick();
    check("bp_c_held_ready", ex_ready, 0);
    check("bp_c_held_head",  mem_wdata, 32'h11);
    mem_ready = 1'b1;
    tick();
    check("bp_out_b",       mem_wdata, 32'h22);
    check("bp_out_b_valid", mem_valid, 1);
    check("bp_ready_again", ex_ready, 1);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    check("bp_out_c",    mem_wdata, 32'h33);
    check("bp_out_c_wd", mem_wd,    4);
    tick();
    check("bp_empty", mem_valid, 0);

    // Streaming 1..8, wreg alternating to carry wreg=0 entries through
    mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, REG_AW'(i), i[0], DATA_W'(i));
      check($sformatf("stream_ready_%0d", i), ex_ready, 1);
      tick();
      check($sformatf("stream_valid_%0d", i), mem_valid, 1);
      check($sformatf("stream_data_%0d", i),  mem_wdata, i);
      check($sformatf("stream_wreg_%0d", i),  mem_wreg,  i & 1);
    end
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("stream_empty", mem_valid, 0);

    // Flush in FULL with ex_valid and mem_ready high
    mem_ready = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'h44);
    tick();
    drive(1'b1, 5'd8, 1'b1, 32'h55);
    tick();
    check("flush_pre_full", ex_ready, 0);
    flush     = 1'b1;
    mem_ready = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 32'h66);
    tick();
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    check("flush_full_valid", mem_valid, 0);
    check("flush_full_ready", ex_ready,  1);
    tick();
    check("flush_full_absent", mem_valid, 0);

    // Flush in BUSY drops a same-cycle accept
    drive(1'b1, 5'd10, 1'b1, 32'h70);
    tick();
    check("flush_busy_pre", mem_valid, 1);
    flush = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 32'h77);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    check("flush_busy_valid", mem_valid, 0);
    tick();
    check("flush_busy_absent", mem_valid, 0);

    // Forwarding: main wd=5 (0xAA), skid wd=6 (0xBB)
    mem_ready = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'hAA);
    tick();
`ifdef EX_MEM_FWD_EN
    check("fwd_main_wd",    fwd_wd,    5);
    check("fwd_main_wdata", fwd_wdata, 32'hAA);
`else
    check("fwd_off_busy_wd", fwd_wd, 0);
`endif
    drive(1'b1, 5'd6, 1'b1, 32'hBB);
    tick();
    drive(1'b0, '0, 1'b0, '0);
`ifdef EX_MEM_FWD_EN
    check("fwd_skid_wd",    fwd_wd,    6);
    check("fwd_skid_wdata", fwd_wdata, 32'hBB);
    check("fwd_skid_wreg",  fwd_wreg,  1);
`else
    check("fwd_off_wd",    fwd_wd,    0);
    check("fwd_off_wdata", fwd_wdata, 0);
    check("fwd_off_wreg",  fwd_wreg,  0);
`endif
    check("fwd_full_head", mem_wdata, 32'hAA);

    // Asynchronous reset mid-operation while FULL
    #2;
    rst = 1'b0;
    #1;
    check("arst_mem_valid", mem_valid, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_mem_wd",    mem_wd,    0);
    check("arst_ex_ready",  ex_ready,  1);
    check("arst_fwd_wdata", fwd_wdata, 0);
    tick();
    rst       = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("arst_after_valid", mem_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port ex_valid  input  1  EX result present this cycle.
REQ-007 SHALL have port ex_wd  input  REG_AW  destination register address from EX.
REQ-008 SHALL have port ex_wreg  input  1  write-back enable from EX.
REQ-009 SHALL have port ex_wdata  input  DATA_W  result data from EX.
REQ-010 SHALL have port ex_ready  output  1  block accepts an EX result this cycle.
REQ-011 SHALL have port mem_valid  output  1  entry presented to MEM.
REQ-012 SHALL have port mem_wd  output  REG_AW  destination address to MEM.
REQ-013 SHALL have port mem_wreg  output  1  write-back enable to MEM.
REQ-014 SHALL have port mem_wdata  output  DATA_W  result data to MEM.
REQ-015 SHALL have port mem_ready  input  1  MEM consumes the presented entry.
REQ-016 SHALL have ports fwd_wreg (output, 1), fwd_wd (output, REG_AW) and fwd_wdata (output, DATA_W), carrying bypass data to ID.

Function
REQ-017 SHALL hold two entries: main, which drives the mem_* outputs, and skid; each entry stores wd, wreg, wdata and a valid bit.
REQ-018 SHALL define an accept as ex_valid & ex_ready, and a drain as mem_valid & mem_ready.
REQ-019 SHALL drive ex_ready = ~skid.valid combinationally, with no dependence on mem_ready.
REQ-020 SHALL drive mem_valid = main.valid, mem_wd = main.wd, mem_wdata = main.wdata, and mem_wreg = main.valid & main.wreg.
REQ-021 SHALL implement states EMPTY (no valid entry), BUSY (main valid only) and FULL (main and skid valid).
REQ-022 SHALL, in EMPTY: accept -> load main, go to BUSY; no accept -> stay in EMPTY.
REQ-023 SHALL, in BUSY:
- accept with drain -> load main with the new entry, stay in BUSY;
- accept without drain -> load skid, go to FULL;
- drain without accept -> clear main.valid, go to EMPTY;
- neither -> hold.
REQ-024 SHALL, in FULL: drain -> copy skid into main, clear skid.valid, go to BUSY; no drain -> hold both entries.
REQ-025 SHALL give a latency of exactly 1 cycle from accept to mem_valid when the block is in EMPTY, or in BUSY with a drain.
REQ-026 SHALL sustain one transfer per cycle while mem_ready stays high.
REQ-027 SHALL, on flush, clear both valid bits at the next edge, dropping any same-cycle accept and drain; flush overrides every other transition.
REQ-028 SHALL never duplicate, reorder or lose an accepted entry unless a flush occurs.
REQ-029 SHALL carry entries with ex_wreg=0 through the pipeline unchanged.
REQ-030 SHALL keep stored wd, wreg and wdata unchanged whenever the entry is not loaded.

Reset
REQ-031 SHALL, while rst=0, asynchronously clear all valid bits and all stored wd, wreg and wdata to zero.
REQ-032 SHALL, during and after reset, drive mem_valid=0, mem_wreg=0, mem_wd=0, mem_wdata=0, ex_ready=1 and all fwd_* outputs to 0.
REQ-033 SHALL, when reset is asserted mid-operation, discard all held entries with no partial transfer.

Configuration
REQ-034 SHALL compile the forwarding path only when macro EX_MEM_FWD_EN is defined.
REQ-035 SHALL, with EX_MEM_FWD_EN defined, drive fwd_* from the youngest valid entry: skid if skid.valid, else main if main.valid; otherwise fwd_wreg=0.
REQ-036 SHALL, without EX_MEM_FWD_EN, keep the fwd_* ports present and tie them to 0.

Verification
REQ-037 SHALL cover single transfer: EMPTY, ex_valid=1, wd=3, wdata=0x0000_00FF, mem_ready=1 -> next cycle mem_valid=1, mem_wd=3, mem_wdata=0xFF, ex_ready=1.
REQ-038 SHALL cover backpressure: mem_ready=0, entries A=0x11 then B=0x22 -> FULL, ex_ready=0 and C is held off; then mem_ready=1 -> MEM receives 0x11, 0x22, C in order.
REQ-039 SHALL cover streaming: mem_ready=1 with 8 back-to-back entries 0x1..0x8 -> one output per cycle, in order, ex_ready constantly 1.
REQ-040 SHALL cover flush: in FULL, flush=1 together with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, and the new entry is absent.
REQ-041 SHALL cover mid-operation reset: in FULL, rst pulled low between edges -> mem_valid=0 and mem_wdata=0 immediately, without waiting for a clock edge.
REQ-042 SHALL cover forwarding: with EX_MEM_FWD_EN defined, main wd=5 (0xAA) and skid wd=6 (0xBB) -> fwd_wd=6, fwd_wdata=0xBB; without the macro, all fwd_* outputs are 0.
